// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, the control
// pattern written into MEM/WB when no instruction retires, and a helper
// that classifies an instruction as a data-memory access.
package pipe_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic wreg;
        logic m2reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0};

    function automatic logic is_access(input logic m2reg, input logic wmem);
        return m2reg | wmem;
    endfunction

endpackage

// File: rtl/pipe_mem_wb_reg.sv
// MEM/WB pipeline register. Every edge it either captures the retiring
// instruction or writes a bubble; a bubble only clears the control bits and
// leaves the data fields untouched. Load data is captured for loads only.
module MEM_WB_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        load_bubble,
    input  logic        mem_wreg,
    input  logic        mem_m2reg,
    input  logic [4:0]  mem_wn,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rdata,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_wn,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_mem_data
);

    // Capture the instruction, insert a bubble, or clear everything on reset
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wb_wreg       <= 1'b0;
            wb_m2reg      <= 1'b0;
            wb_wn         <= 5'd0;
            wb_alu_result <= 32'd0;
            wb_mem_data   <= 32'd0;
        end else if (load_bubble) begin
            wb_wreg  <= WB_BUBBLE.wreg;
            wb_m2reg <= WB_BUBBLE.m2reg;
        end else begin
            wb_wreg       <= mem_wreg;
            wb_m2reg      <= mem_m2reg;
            wb_wn         <= mem_wn;
            wb_alu_result <= mem_alu_result;
            if (mem_m2reg) begin
                wb_mem_data <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/pipe_mem.sv
// MEM stage of the pipeline: issues data-memory requests, stalls the front
// of the pipe while memory is slow, aborts an access after WAIT_MAX wait
// cycles, and feeds the MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose
// address is not word aligned (no request, misalign pulse, bubble).
module pipe_mem
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        MEMwreg,
    input  logic        MEMm2reg,
    input  logic        MEMwmem,
    input  logic [4:0]  MEMwn,
    input  logic [31:0] MEMaluResult,
    input  logic [31:0] MEMdi,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        dmem_err,
    output logic        misalign,
    output logic        WBwreg,
    output logic        WBm2reg,
    output logic [4:0]  WBwn,
    output logic [31:0] WBaluResult,
    output logic [31:0] WBmemData
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    logic [0:0] state;
    logic [0:0] next_state;
    logic [7:0] wait_cnt;
    logic [7:0] next_cnt;
    logic       access;
    logic       misaligned;
    logic       load_bubble;

    assign access = is_access(MEMm2reg, MEMwmem);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = access && (MEMaluResult[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The environment holds the MEM inputs stable during a stall, so the
    // request fields can be driven straight from them in both states
    assign dmem_we    = dmem_req & MEMwmem;
    assign dmem_addr  = MEMaluResult;
    assign dmem_wdata = MEMdi;

    // Decide request, stall, abort and bubble for this cycle and the next state
    always_comb begin
        dmem_req    = 1'b0;
        stall       = 1'b0;
        dmem_err    = 1'b0;
        misalign    = 1'b0;
        load_bubble = 1'b0;
        next_state  = state;
        next_cnt    = wait_cnt;
        if (clrn) begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            misalign    = 1'b1;
                            load_bubble = 1'b1;
                        end else begin
                            dmem_req = 1'b1;
                            if (!dmem_ready) begin
                                stall       = 1'b1;
                                load_bubble = 1'b1;
                                next_state  = WAIT;
                                next_cnt    = 8'd1;
                            end
                        end
                    end
                end
                WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        next_state = IDLE;
                        next_cnt   = 8'd0;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        dmem_err    = 1'b1;
                        load_bubble = 1'b1;
                        next_state  = IDLE;
                        next_cnt    = 8'd0;
                    end else begin
                        stall       = 1'b1;
                        load_bubble = 1'b1;
                        next_cnt    = wait_cnt + 8'd1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = 8'd0;
                end
            endcase
        end
    end

    // Advance the access FSM and wait counter; reset abandons any access
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
        end
    end

    MEM_WB_reg u_mem_wb (
        .clk            (clk),
        .clrn           (clrn),
        .load_bubble    (load_bubble),
        .mem_wreg       (MEMwreg),
        .mem_m2reg      (MEMm2reg),
        .mem_wn         (MEMwn),
        .mem_alu_result (MEMaluResult),
        .mem_rdata      (dmem_rdata),
        .wb_wreg        (WBwreg),
        .wb_m2reg       (WBm2reg),
        .wb_wn          (WBwn),
        .wb_alu_result  (WBaluResult),
        .wb_mem_data    (WBmemData)
    );

endmodule

// File: tb/tb_pipe_mem.sv
// Self-checking bench for pipe_mem: a transaction-level model predicts the
// combinational memory-side outputs and the MEM/WB contents every cycle,
// and directed vectors carry hand-computed literal expectations.
module tb_pipe_mem;

    localparam int WAIT_MAX = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clrn;
    logic        MEMwreg, MEMm2reg, MEMwmem;
    logic [4:0]  MEMwn;
    logic [31:0] MEMaluResult, MEMdi;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic        stall, dmem_err, misalign;
    logic        WBwreg, WBm2reg;
    logic [4:0]  WBwn;
    logic [31:0] WBaluResult, WBmemData;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_mem #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .MEMwreg      (MEMwreg),
        .MEMm2reg     (MEMm2reg),
        .MEMwmem      (MEMwmem),
        .MEMwn        (MEMwn),
        .MEMaluResult (MEMaluResult),
        .MEMdi        (MEMdi),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .stall        (stall),
        .dmem_err     (dmem_err),
        .misalign     (misalign),
        .WBwreg       (WBwreg),
        .WBm2reg      (WBm2reg),
        .WBwn         (WBwn),
        .WBaluResult  (WBaluResult),
        .WBmemData    (WBmemData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wreg, input logic m2reg, input logic wmem,
                                 input logic [4:0] wn, input logic [31:0] alu,
                                 input logic [31:0] di, input logic ready,
                                 input logic [31:0] rdata);
        MEMwreg      = wreg;
        MEMm2reg     = m2reg;
        MEMwmem      = wmem;
        MEMwn        = wn;
        MEMaluResult = alu;
        MEMdi        = di;
        dmem_ready   = ready;
        dmem_rdata   = rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the expected MEM/WB contents plus how many cycles the
    // current access has already been stalled
    bit          model_valid = 1'b0;
    logic        m_wreg, m_m2reg;
    logic [4:0]  m_wn;
    logic [31:0] m_alu, m_mdata;
    int          m_waited = 0;

    logic e_acc, e_mis, e_req, e_stall, e_err, e_misalign;

    always_comb begin
        e_acc      = MEMm2reg | MEMwmem;
        e_mis      = ALIGN_CHK && e_acc && (MEMaluResult % 4 != 0);
        e_req      = clrn && e_acc && !e_mis;
        e_stall    = e_req && !dmem_ready && (m_waited < WAIT_MAX);
        e_err      = e_req && !dmem_ready && (m_waited >= WAIT_MAX);
        e_misalign = clrn && e_mis;
    end

    // Model update: what must land in MEM/WB at each edge
    always @(posedge clk) begin
        if (!clrn) begin
            {m_wreg, m_m2reg, m_wn, m_alu, m_mdata} = '0;
            m_waited    = 0;
            model_valid = 1'b1;
        end else if (!e_acc || (!e_mis && dmem_ready)) begin
            m_wreg  = MEMwreg;
            m_m2reg = MEMm2reg;
            m_wn    = MEMwn;
            m_alu   = MEMaluResult;
            if (MEMm2reg) m_mdata = dmem_rdata;
            m_waited = 0;
        end else begin
            m_wreg  = 1'b0;
            m_m2reg = 1'b0;
            if (!e_mis && m_waited < WAIT_MAX) m_waited = m_waited + 1;
            else m_waited = 0;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
            checkOutput("stall", {31'd0, stall}, {31'd0, e_stall});
            checkOutput("dmem_err", {31'd0, dmem_err}, {31'd0, e_err});
            checkOutput("misalign", {31'd0, misalign}, {31'd0, e_misalign});
            if (e_req) begin
                checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, MEMwmem});
                checkOutput("dmem_addr", dmem_addr, MEMaluResult);
                checkOutput("dmem_wdata", dmem_wdata, MEMdi);
            end
            checkOutput("WBwreg", {31'd0, WBwreg}, {31'd0, m_wreg});
            checkOutput("WBm2reg", {31'd0, WBm2reg}, {31'd0, m_m2reg});
            checkOutput("WBwn", {27'd0, WBwn}, {27'd0, m_wn});
            checkOutput("WBaluResult", WBaluResult, m_alu);
            checkOutput("WBmemData", WBmemData, m_mdata);
        end
    end

    initial begin
        clrn = 1'b0;
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
        tick();
        tick();
        checkOutput("reset_wbwreg", {31'd0, WBwreg}, 32'd0);
        checkOutput("reset_wbalu", WBaluResult, 32'd0);
        checkOutput("reset_wbmem", WBmemData, 32'd0);
        clrn = 1'b1;

        // ALU instruction passes straight through
        applyStimulus(1, 0, 0, 5'd5, 32'h1234, 32'd0, 0, 32'd0);
        #1 checkOutput("alu_noreq", {31'd0, dmem_req}, 32'd0);
        tick();
        checkOutput("alu_wbwreg", {31'd0, WBwreg}, 32'd1);
        checkOutput("alu_wbwn", {27'd0, WBwn}, 32'd5);
        checkOutput("alu_wbalu", WBaluResult, 32'h1234);

        // Zero-wait load
        applyStimulus(1, 1, 0, 5'd7, 32'h100, 32'd0, 1, 32'hDEADBEEF);
        #1 checkOutput("ld0_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("ld0_wbm2reg", {31'd0, WBm2reg}, 32'd1);
        checkOutput("ld0_wbmem", WBmemData, 32'hDEADBEEF);

        // Store that completes after three wait cycles
        applyStimulus(0, 0, 1, 5'd0, 32'h200, 32'hA5A5A5A5, 0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("st_stall", {31'd0, stall}, 32'd1);
            checkOutput("st_we", {31'd0, dmem_we}, 32'd1);
            checkOutput("st_addr", dmem_addr, 32'h200);
            tick();
            checkOutput("st_bubble", {30'd0, WBwreg, WBm2reg}, 32'd0);
            checkOutput("st_bubble_hold", WBaluResult, 32'h100);
        end
        dmem_ready = 1'b1;
        #1 checkOutput("st_done_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("st_wbwreg", {31'd0, WBwreg}, 32'd0);
        checkOutput("st_wbalu", WBaluResult, 32'h200);
        checkOutput("st_mem_hold", WBmemData, 32'hDEADBEEF);

        // Back-to-back load issues immediately
        applyStimulus(1, 1, 0, 5'd9, 32'h104, 32'd0, 1, 32'h11112222);
        #1 checkOutput("b2b_req", {31'd0, dmem_req}, 32'd1);
        tick();
        checkOutput("b2b_wbmem", WBmemData, 32'h11112222);

        // Load that never completes: four stall cycles, then abort
        applyStimulus(1, 1, 0, 5'd3, 32'h300, 32'd0, 0, 32'd0);
        for (int i = 0; i < WAIT_MAX; i++) begin
            #1 checkOutput("to_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        #1;
        checkOutput("to_stall_end", {31'd0, stall}, 32'd0);
        checkOutput("to_err", {31'd0, dmem_err}, 32'd1);
        tick();
        checkOutput("to_bubble", {31'd0, WBwreg}, 32'd0);
        checkOutput("to_hold", WBaluResult, 32'h104);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
        #1 checkOutput("to_err_once", {31'd0, dmem_err}, 32'd0);
        tick();

        // Reset on the second wait cycle of a load
        applyStimulus(1, 1, 0, 5'd4, 32'h400, 32'd0, 0, 32'd0);
        tick();
        tick();
        clrn = 1'b0;
        #1;
        checkOutput("rw_stall", {31'd0, stall}, 32'd0);
        checkOutput("rw_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rw_err", {31'd0, dmem_err}, 32'd0);
        tick();
        checkOutput("rw_wbwn", {27'd0, WBwn}, 32'd0);
        checkOutput("rw_wbmem", WBmemData, 32'd0);
        clrn = 1'b1;
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
        #1 checkOutput("rw_idle_req", {31'd0, dmem_req}, 32'd0);
        tick();

        // Misaligned load
        applyStimulus(1, 1, 0, 5'd6, 32'h103, 32'd0, 1, 32'h55);
        #1;
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mis_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("mis_pulse", {31'd0, misalign}, 32'd1);
        tick();
        checkOutput("mis_bubble", {31'd0, WBwreg}, 32'd0);
`else
        checkOutput("mis_req", {31'd0, dmem_req}, 32'd1);
        checkOutput("mis_addr", dmem_addr, 32'h103);
        checkOutput("mis_pulse", {31'd0, misalign}, 32'd0);
        tick();
        checkOutput("mis_wbmem", WBmemData, 32'h55);
`endif
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 32'd0);
        #1 checkOutput("mis_once", {31'd0, misalign}, 32'd0);
        tick();

        // A run of ALU results
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1, 0, 0, 5'(i), 32'(i * 3), 32'd0, 0, 32'd0);
            tick();
            checkOutput("alu_run", WBaluResult, 32'(i * 3));
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_mem.md
PIPE_MEM -- requirements
Module: pipe_mem

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum wait cycles per memory access before abort (range 1..255).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: clrn  input  1  reset, synchronous, active-low.
REQ-004 Port: MEMwreg, MEMm2reg, MEMwmem  input  1 each  control bits from the EX/MEM register: register write, load select, store.
REQ-005 Port: MEMwn  input  5  destination register number.
REQ-006 Port: MEMaluResult  input  32  ALU result; it is the memory address for loads and stores.
REQ-007 Port: MEMdi  input  32  store data.
REQ-008 Port: dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-009 Port: dmem_addr, dmem_wdata  output  32 each  memory address and write data.
REQ-010 Port: dmem_rdata  input  32  read data, valid when dmem_ready=1.
REQ-011 Port: dmem_ready  input  1  access completes in the cycle it is high while dmem_req=1.
REQ-012 Port: stall  output  1  freezes IF/ID/EX and the EX/MEM register.
REQ-013 Port: dmem_err, misalign  output  1 each  one-cycle pulses for timeout abort and misaligned access.
REQ-014 Port: WBwreg, WBm2reg  output  1 each  registered control bits for writeback.
REQ-015 Port: WBwn  output  5  registered destination register number.
REQ-016 Port: WBaluResult, WBmemData  output  32 each  registered ALU result and load data.

Function
REQ-017 An access is MEMm2reg|MEMwmem; a non-access instruction is copied into MEM/WB on the next edge with no request and stall=0.
REQ-018 FSM has two states, IDLE and WAIT; there is also a wait counter of 8 bits.
REQ-019 In IDLE with an access: dmem_req=1 combinationally, dmem_we=MEMwmem, dmem_addr=MEMaluResult, dmem_wdata=MEMdi.
REQ-020 In IDLE, if dmem_ready=1: zero-wait completion, stall=0, and MEM/WB captures the inputs plus dmem_rdata on the same edge.
REQ-021 In IDLE, if dmem_ready=0: stall=1, go to WAIT, counter=1, and MEM/WB loads a bubble (WBwreg=0, WBm2reg=0).
REQ-022 In WAIT: dmem_req stays high with unchanged address, data and we; the environment holds the MEM* inputs stable while stall=1.
REQ-023 In WAIT with dmem_ready=1: stall=0 that cycle, MEM/WB captures the instruction and dmem_rdata, and the FSM returns to IDLE.
REQ-024 In WAIT with dmem_ready=0 and counter=WAIT_MAX: abort, stall=0, dmem_err=1 for one cycle, a bubble is written, and the FSM returns to IDLE; otherwise stall=1 and counter increments.
REQ-025 A store writes WBwreg=MEMwreg (normally 0); WBmemData is captured only for loads and holds its previous value otherwise.
REQ-026 A bubble holds WBwn, WBaluResult and WBmemData at their previous values.
REQ-027 Back-to-back accesses are allowed: completion in WAIT followed by a new access issues its request in the very next IDLE cycle.

Reset
REQ-028 When clrn=0 at a clock edge: state=IDLE, counter=0, and all WB* outputs=0.
REQ-029 While clrn=0: dmem_req=0, stall=0, dmem_err=0 and misalign=0.
REQ-030 Reset during WAIT abandons the access with no dmem_err pulse.

Configuration
REQ-031 With MEM_ALIGN_CHECK_EN defined, an access with MEMaluResult[1:0]!=0 issues no request and pulses misalign for one cycle.
REQ-032 Under MEM_ALIGN_CHECK_EN, a misaligned access also writes a bubble and does not stall.
REQ-033 Without MEM_ALIGN_CHECK_EN, misalign is tied to 0 and address bits [1:0] pass through unchecked.

Structure
REQ-034 Shared package pipe_pkg holds the IDLE/WAIT state encoding and the bubble constant.
REQ-035 The MEM/WB register is a sub-module MEM_WB_reg with a load-bubble input; the FSM and counter stay in pipe_mem.

Verification
REQ-036 ALU instruction (MEMwreg=1, MEMwn=5, MEMaluResult=0x1234) -> next edge WBwreg=1, WBwn=5, WBaluResult=0x1234, no dmem_req.
REQ-037 Load at address 0x100, dmem_ready=1 in the same cycle, rdata=0xDEADBEEF -> stall never asserted; next edge WBm2reg=1 and WBmemData=0xDEADBEEF.
REQ-038 Store at 0x200 with data 0xA5A5A5A5, ready after 3 cycles -> stall=1 for 3 cycles, dmem_we=1 and dmem_addr=0x200 held throughout, 3 bubbles, then WBwreg=0.
REQ-039 Load with WAIT_MAX=4 and ready never asserted -> stall high for 4 cycles, then dmem_err pulses once, a bubble is written, and the FSM returns to IDLE.
REQ-040 Reset (clrn=0) on the 2nd WAIT cycle -> next edge all WB*=0, state IDLE; stall, dmem_req and dmem_err are 0 from the edge where clrn was sampled low.
REQ-041 With MEM_ALIGN_CHECK_EN, load at 0x103 -> no dmem_req, misalign pulses once, bubble; without the macro, a request is issued at address 0x103.
